// File: rtl/rs_pkg.sv
// Shared types and constants for the Reed-Solomon stream encoder.
package rs_pkg;

  localparam int GF_W     = 8;
  localparam int MAX_SYMS = 255;

  typedef logic [GF_W-1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GEN    = 2'd1,
    DATA   = 2'd2,
    PARITY = 2'd3
  } state_t;

  localparam logic [8:0] POLY_11D  = 9'h11D;
  localparam sym_t       ALPHA_DEF = 8'h02;

endpackage

// File: rtl/rs_stream_encoder_gf_mul.sv
// Combinational GF(2^8) multiplier with a run-time reduction polynomial.
module gf_mul
  import rs_pkg::*;
(
  input  sym_t       a,
  input  sym_t       b,
  input  logic [8:0] poly,
  output sym_t       p
);

  // Shift-and-add: each partial product of a is reduced as soon as it overflows x^7.
  always_comb begin
    sym_t       acc;
    sym_t       sh;
    logic [8:0] sh9;
    acc = '0;
    sh  = a;
    sh9 = '0;
    for (int i = 0; i < GF_W; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh9 = {sh, 1'b0};
      if (sh9[8]) sh9 = sh9 ^ poly;
      sh = sh9[7:0];
    end
    p = acc;
  end

endmodule

// File: rtl/rs_stream_encoder.sv
// Systematic RS encoder over GF(2^8): builds g(x) from the first root, then streams
// message symbols followed by parity. Optional feature macro: RS_GEN_CACHE_EN.
module rs_stream_encoder
  import rs_pkg::*;
#(
  parameter int MAX_PARITY = 32,
  parameter int SYM_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [8:0]       cfg_poly,
  input  logic [7:0]       cfg_alpha,
  input  logic [7:0]       cfg_first_root,
  input  logic [5:0]       cfg_nparity,
  input  logic [7:0]       cfg_msg_len,
  input  logic [SYM_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SYM_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             cfg_err
);

  state_t     state_q, state_d;

  logic [8:0] poly_q;
  sym_t       alpha_q;
  sym_t       root_q;
  logic [5:0] np_q;
  logic [7:0] len_q;
  logic [5:0] k_q;
  logic [7:0] cnt_q;
  logic [5:0] pcnt_q;

  // g holds coefficients 0..MAX_PARITY-1; the monic top term is implicit when np == MAX_PARITY.
  sym_t       g_q     [MAX_PARITY];
  sym_t       r_q     [MAX_PARITY];
  sym_t       g_gen   [MAX_PARITY];
  sym_t       r_data  [MAX_PARITY];
  sym_t       r_shift [MAX_PARITY];
  sym_t       prod    [MAX_PARITY];

  sym_t       out_data_q;
  logic       out_valid_q;
  logic       out_last_q;
  logic       cfg_err_q;

  sym_t       r_top;
  sym_t       fb;
  sym_t       mul_a;
  sym_t       root_next;
  logic       adv;
  logic       accept;
  logic       cfg_bad;
  logic       gen_done;
  logic       cache_hit;

  assign adv     = !out_valid_q || out_ready;
  assign accept  = in_ready && in_valid;
  assign cfg_bad = (cfg_nparity == 6'd0) ||
                   (int'(cfg_nparity) > MAX_PARITY) ||
                   (int'(cfg_msg_len) + int'(cfg_nparity) > MAX_SYMS);
  assign gen_done = (state_q == GEN) && (k_q == np_q - 6'd1);

  // The LFSR multipliers double as the g(x) builder: during GEN they scale g by the root.
  assign fb    = in_data ^ r_top;
  assign mul_a = (state_q == GEN) ? root_q : fb;

  for (genvar gi = 0; gi < MAX_PARITY; gi++) begin : g_mul
    gf_mul u_mul (
      .a    (mul_a),
      .b    (g_q[gi]),
      .poly (poly_q),
      .p    (prod[gi])
    );
  end

  gf_mul u_root_mul (
    .a    (root_q),
    .b    (alpha_q),
    .poly (poly_q),
    .p    (root_next)
  );

  always_comb begin
    r_top = '0;
    for (int i = 0; i < MAX_PARITY; i++) begin
      if (np_q == 6'(i + 1)) r_top = r_q[i];
    end
  end

  // Next-value vectors; stages at or above np are forced to zero so only np stages are live.
  always_comb begin
    g_gen[0]   = prod[0];
    r_data[0]  = (np_q != 6'd0) ? prod[0] : '0;
    r_shift[0] = '0;
    for (int i = 1; i < MAX_PARITY; i++) begin
      g_gen[i]   = g_q[i-1] ^ prod[i];
      r_data[i]  = (6'(i) < np_q) ? (r_q[i-1] ^ prod[i]) : '0;
      r_shift[i] = (6'(i) < np_q) ? r_q[i-1] : '0;
    end
  end

`ifdef RS_GEN_CACHE_EN
  logic [8:0] tag_poly_q;
  sym_t       tag_alpha_q;
  sym_t       tag_root_q;
  logic [5:0] tag_np_q;
  logic       tag_vld_q;

  assign cache_hit = tag_vld_q && (tag_poly_q == cfg_poly) && (tag_alpha_q == cfg_alpha) &&
                     (tag_root_q == cfg_first_root) && (tag_np_q == cfg_nparity);

  // Tags are loaded when a GEN starts and only marked valid once that GEN completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_vld_q   <= 1'b0;
      tag_poly_q  <= '0;
      tag_alpha_q <= '0;
      tag_root_q  <= '0;
      tag_np_q    <= '0;
    end else if (state_q == IDLE && start && !cfg_bad && !cache_hit) begin
      tag_vld_q   <= 1'b0;
      tag_poly_q  <= cfg_poly;
      tag_alpha_q <= cfg_alpha;
      tag_root_q  <= cfg_first_root;
      tag_np_q    <= cfg_nparity;
    end else if (gen_done) begin
      tag_vld_q   <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && !cfg_bad) state_d = cache_hit ? DATA : GEN;
      end
      GEN: begin
        if (gen_done) state_d = DATA;
      end
      DATA: begin
        if ((cnt_q == len_q) || (accept && (cnt_q + 8'd1 == len_q))) state_d = PARITY;
      end
      PARITY: begin
        if (adv && (pcnt_q == np_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    in_ready = (state_q == DATA) && adv && (cnt_q != len_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      poly_q      <= '0;
      alpha_q     <= '0;
      root_q      <= '0;
      np_q        <= '0;
      len_q       <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      pcnt_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int i = 0; i < MAX_PARITY; i++) begin
        g_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err_q <= 1'b1;
            end else begin
              cfg_err_q <= 1'b0;
              poly_q    <= cfg_poly;
              alpha_q   <= cfg_alpha;
              root_q    <= cfg_first_root;
              np_q      <= cfg_nparity;
              len_q     <= cfg_msg_len;
              k_q       <= '0;
              cnt_q     <= '0;
              pcnt_q    <= '0;
              for (int i = 0; i < MAX_PARITY; i++) begin
                r_q[i] <= '0;
                if (!cache_hit) g_q[i] <= (i == 0) ? 8'h01 : 8'h00;
              end
            end
          end
        end
        GEN: begin
          g_q    <= g_gen;
          root_q <= root_next;
          k_q    <= k_q + 6'd1;
        end
        DATA: begin
          if (accept) begin
            r_q         <= r_data;
            out_data_q  <= in_data;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            cnt_q       <= cnt_q + 8'd1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        PARITY: begin
          if (adv) begin
            if (pcnt_q != np_q) begin
              out_data_q  <= r_top;
              out_valid_q <= 1'b1;
              out_last_q  <= (pcnt_q == np_q - 6'd1);
              r_q         <= r_shift;
              pcnt_q      <= pcnt_q + 6'd1;
            end else begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Scoreboard bench for rs_stream_encoder: polynomial-division reference model, random traffic.
module tb_rs_stream_encoder;
  import rs_pkg::*;

  localparam int MAXP = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [8:0] cfg_poly;
  logic [7:0] cfg_alpha;
  logic [7:0] cfg_first_root;
  logic [5:0] cfg_nparity;
  logic [7:0] cfg_msg_len;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       cfg_err;

  rs_stream_encoder #(.MAX_PARITY(MAXP), .SYM_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_poly       (cfg_poly),
    .cfg_alpha      (cfg_alpha),
    .cfg_first_root (cfg_first_root),
    .cfg_nparity    (cfg_nparity),
    .cfg_msg_len    (cfg_msg_len),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .busy           (busy),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] msg_q[$];
  int         ready_mode = 0;
  int         pat_idx = 0;
  int         pop_cnt = 0;
  int         cyc = 0;
  int         first_cyc = 0;
  int         span = 0;
  bit         new_cw = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b,
                                      input logic [8:0] poly);
    logic [14:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (15'(poly) << (i - 8));
    return prod[7:0];
  endfunction

  // g(x) = prod (x + root_j); parity = m(x)*x^np mod g(x), pushed highest degree first.
  task automatic model_push(input logic [8:0] poly, input logic [7:0] alpha,
                            input logic [7:0] root, input int np);
    logic [7:0] g[0:MAXP];
    logic [7:0] buf_a[0:287];
    logic [7:0] rt;
    logic [7:0] c;
    int         len;
    len = msg_q.size();
    for (int i = 0; i <= MAXP; i++) g[i] = '0;
    g[0] = 8'h01;
    rt = root;
    for (int j = 0; j < np; j++) begin
      for (int i = j + 1; i >= 1; i--) g[i] = g[i-1] ^ gmul(rt, g[i], poly);
      g[0] = gmul(rt, g[0], poly);
      rt = gmul(rt, alpha, poly);
    end
    for (int i = 0; i < 288; i++) buf_a[i] = '0;
    for (int i = 0; i < len; i++) buf_a[np + len - 1 - i] = msg_q[i];
    for (int d = len + np - 1; d >= np; d--) begin
      c = buf_a[d];
      for (int i = 0; i <= np; i++) buf_a[d - np + i] = buf_a[d - np + i] ^ gmul(c, g[i], poly);
    end
    for (int i = 0; i < len; i++) exp_q.push_back({1'b0, msg_q[i]});
    for (int i = np - 1; i >= 0; i--) exp_q.push_back({(i == 0), buf_a[i]});
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       prev_stall = 1'b0;
  logic [8:0] prev_sym = '0;

  always @(negedge clk) begin
    logic [8:0] e;
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", int'(out_valid), 1);
        check("stall_sym_held", int'({out_last, out_data}), int'(prev_sym));
      end
      if (out_valid && !out_ready) check("stall_in_ready_low", int'(in_ready), 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected actual=0x%0h expected=none", {out_last, out_data});
        end else begin
          e = exp_q.pop_front();
          check("out_sym", int'({out_last, out_data}), int'(e));
          pop_cnt++;
          if (new_cw) begin
            first_cyc = cyc;
            new_cw = 1'b0;
          end
          if (out_last) span = cyc - first_cyc + 1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sym   = {out_last, out_data};
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 2) != 0);
      default: begin
        out_ready = ((pat_idx % 3) == 0);
        pat_idx++;
      end
    endcase
  endtask

  task automatic start_cw(input logic [8:0] poly, input logic [7:0] alpha,
                          input logic [7:0] root, input int np, input int len);
    cfg_poly       = poly;
    cfg_alpha      = alpha;
    cfg_first_root = root;
    cfg_nparity    = 6'(np);
    cfg_msg_len    = 8'(len);
    start          = 1'b1;
    step();
    start          = 1'b0;
  endtask

  task automatic send_sym(input logic [7:0] d, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && waited < 300) begin
      step();
      #1;
      waited++;
    end
    if (waited >= 300) check("in_ready_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int guard;
    guard = 0;
    #1;
    while ((busy || exp_q.size() != 0) && guard < 3000) begin
      step();
      #1;
      guard++;
    end
    check(name, int'(guard < 3000), 1);
  endtask

  task automatic feed_msg(input int np);
    int w;
    for (int i = 0; i < msg_q.size(); i++) begin
      send_sym(msg_q[i], w);
`ifndef RS_GEN_CACHE_EN
      if (i == 0) check("gen_cycles", w, np);
`endif
    end
  endtask

  task automatic run_model(input logic [8:0] poly, input logic [7:0] alpha,
                           input logic [7:0] root, input int np, input int len,
                           input int mode, input bit zero_msg);
    ready_mode = mode;
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(zero_msg ? 8'h00 : 8'($urandom));
    model_push(poly, alpha, root, np);
    new_cw = 1'b1;
    start_cw(poly, alpha, root, np, len);
    feed_msg(np);
    wait_done("codeword_done");
    if (mode == 0) check("no_bubble_span", span, len + np);
  endtask

  task automatic run_scenario1(input int mode);
    ready_mode = mode;
    msg_q.delete();
    msg_q.push_back(8'h01);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h003);
    exp_q.push_back(9'h102);
    new_cw = 1'b1;
    start_cw(POLY_11D, ALPHA_DEF, 8'h01, 2, 1);
    #1;
    check("cfg_err_cleared", int'(cfg_err), 0);
    feed_msg(2);
    wait_done("scenario1_done");
  endtask

  initial begin
    int guard;
    int base;
    rst_n = 1'b0;
    start = 1'b0;
    cfg_poly = '0;
    cfg_alpha = '0;
    cfg_first_root = '0;
    cfg_nparity = '0;
    cfg_msg_len = '0;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    rst_n = 1'b1;
    step();

    run_scenario1(0);

    // np=4, msg_len=0: four zero parity symbols, last on the fourth.
    ready_mode = 0;
    for (int i = 0; i < 3; i++) exp_q.push_back(9'h000);
    exp_q.push_back(9'h100);
    new_cw = 1'b1;
    start_cw(POLY_11D, ALPHA_DEF, 8'h01, 4, 0);
    wait_done("np4_len0_done");
    check("np4_len0_span", span, 4);

    run_model(POLY_11D, ALPHA_DEF, 8'h01, 4, 16, 0, 1'b1);
    run_scenario1(2);

    // Illegal configurations stay idle with a sticky error.
    start_cw(POLY_11D, ALPHA_DEF, 8'h01, 0, 1);
    #1;
    check("np0_cfg_err", int'(cfg_err), 1);
    check("np0_busy", int'(busy), 0);
    start_cw(POLY_11D, ALPHA_DEF, 8'h01, 8, 250);
    #1;
    check("len_over_cfg_err", int'(cfg_err), 1);
    check("len_over_busy", int'(busy), 0);
    start_cw(POLY_11D, ALPHA_DEF, 8'h01, 33, 4);
    #1;
    check("np33_cfg_err", int'(cfg_err), 1);
    start_cw(POLY_11D, ALPHA_DEF, 8'h01, 1, 255);
    #1;
    check("sum256_cfg_err", int'(cfg_err), 1);
    check("sum256_busy", int'(busy), 0);
    run_scenario1(1);

    // Largest legal codeword: 223 + 32 = 255 symbols.
    run_model(POLY_11D, ALPHA_DEF, 8'h01, 32, 223, 1, 1'b0);

    for (int n = 0; n < 14; n++) begin
      run_model({1'b1, 8'($urandom)}, 8'($urandom), 8'($urandom),
                $urandom_range(1, MAXP), $urandom_range(0, 30), $urandom_range(0, 2), 1'b0);
    end

    // Reset in the middle of the parity phase, then a clean codeword.
    ready_mode = 1;
    base = pop_cnt;
    msg_q.delete();
    msg_q.push_back(8'($urandom));
    msg_q.push_back(8'($urandom));
    model_push(POLY_11D, ALPHA_DEF, 8'h01, 8);
    new_cw = 1'b1;
    start_cw(POLY_11D, ALPHA_DEF, 8'h01, 8, 2);
    feed_msg(8);
    guard = 0;
    while (pop_cnt < base + 4 && guard < 500) begin
      step();
      guard++;
    end
    check("parity_reach", int'(guard < 500), 1);
    rst_n = 1'b0;
    exp_q.delete();
    step();
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_out_last", int'(out_last), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    step();
    rst_n = 1'b1;
    step();
    run_scenario1(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
